// File: rtl/generador_sonido.sv
// generador_sonido: one square-wave beep burst per rising edge of pulso_sonido, then a silent gap; optional two-tone chirp under `TWO_TONE_EN
module generador_sonido #(
  parameter int HALF_PERIOD   = 25000,
  parameter int DUR_CYCLES    = 5000000,
  parameter int GAP_CYCLES    = 1000000,
  parameter int HALF_PERIOD_2 = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic pulso_sonido,
  output logic audio_out,
  output logic sonando
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`ifdef TWO_TONE_EN
  localparam int TMAX = HALF_PERIOD > HALF_PERIOD_2 ? HALF_PERIOD : HALF_PERIOD_2;
`else
  localparam int TMAX = HALF_PERIOD;
`endif
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW = $clog2(DUR_CYCLES + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  if (HALF_PERIOD < 1 || DUR_CYCLES < 2 || GAP_CYCLES < 0 || HALF_PERIOD_2 < 1) begin : g_bad_params
    $error("generador_sonido: invalid parameters");
  end
  state_t state_q, state_d;
  logic pulso_prev_q, audio_q, audio_d, sonando_q, sonando_d, pending_q, pending_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d, half;
  logic [DW-1:0] dur_cnt_q, dur_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic trig, tone_end, dur_end, gap_end, start;
  always_comb begin
    trig = pulso_sonido & ~pulso_prev_q;
`ifdef TWO_TONE_EN
    half = dur_cnt_q >= DW'(DUR_CYCLES / 2) ? TW'(HALF_PERIOD_2 - 1) : TW'(HALF_PERIOD - 1);
`else
    half = TW'(HALF_PERIOD - 1);
`endif
    tone_end = tone_cnt_q == half;
    dur_end = dur_cnt_q == DW'(DUR_CYCLES - 1);
    gap_end = gap_cnt_q == GW'(GAP_CYCLES - 1);
    start = (state_q == IDLE && trig) || (state_q == GAP && gap_end && (pending_q || trig));
    state_d = state_q;
    audio_d = audio_q;
    sonando_d = sonando_q;
    pending_d = pending_q;
    tone_cnt_d = tone_cnt_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (start) begin
      state_d = PLAY;
      audio_d = 1'b1;
      sonando_d = 1'b1;
      pending_d = 1'b0;
      tone_cnt_d = '0;
      dur_cnt_d = '0;
      gap_cnt_d = '0;
    end else if (state_q == PLAY) begin
      tone_cnt_d = tone_end ? '0 : tone_cnt_q + 1'b1;
      audio_d = tone_end ? ~audio_q : audio_q;
      dur_cnt_d = trig ? '0 : dur_cnt_q + 1'b1;
`ifdef TWO_TONE_EN
      // Entering the second tone, or a retrigger, restarts the tone phase high.
      if (trig || dur_cnt_q == DW'(DUR_CYCLES / 2 - 1)) begin
        tone_cnt_d = '0;
        audio_d = 1'b1;
      end
`endif
      if (!trig && dur_end) begin
        state_d = GAP_CYCLES == 0 ? IDLE : GAP;
        audio_d = 1'b0;
        sonando_d = 1'b0;
        tone_cnt_d = '0;
        dur_cnt_d = '0;
        gap_cnt_d = '0;
      end
    end else if (state_q == GAP) begin
      pending_d = pending_q | trig;
      gap_cnt_d = gap_end ? '0 : gap_cnt_q + 1'b1;
      state_d = gap_end ? IDLE : GAP;
      if (gap_end) pending_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulso_prev_q <= 1'b0;
      audio_q <= 1'b0;
      sonando_q <= 1'b0;
      pending_q <= 1'b0;
      tone_cnt_q <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pulso_prev_q <= pulso_sonido;
      audio_q <= audio_d;
      sonando_q <= sonando_d;
      pending_q <= pending_d;
      tone_cnt_q <= tone_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
  assign audio_out = audio_q;
  assign sonando = sonando_q;
endmodule
